// File: rtl/dmem_stage_if.sv
// -----------------------------------------------------------------------------
// dmem_stage_if
// Purpose : data-memory bus between the memory-stage access unit and a
//           variable-latency memory. One transfer completes in the cycle
//           where mem_req and mem_ack are both high.
// Signals : mem_req   request (master -> slave)
//           mem_we    1 = write, 0 = read (master -> slave)
//           mem_addr  word-aligned byte address (master -> slave)
//           mem_wdata write data (master -> slave)
//           mem_rdata read data, valid with mem_ack on a read (slave -> master)
//           mem_ack   transfer completes this cycle (slave -> master)
// -----------------------------------------------------------------------------
interface dmem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/dmem_stage.sv
// -----------------------------------------------------------------------------
// dmem_stage
// Purpose : memory-stage data-access unit for a pipelined MIPS core. Stores
//           are posted into a circular write buffer and retire without
//           stalling; loads first drain the buffer (so they never overtake an
//           older store) and then perform one handshaked bus read while StallM
//           holds the pipeline.
// Ports   : clk        clock, all state on the rising edge
//           reset      synchronous, active-low reset
//           MemReadM   M-stage load
//           MemWriteM  M-stage store (wins when both are set)
//           AluOutM    byte address of the access
//           WriteDataM store data
//           ReadDataM  load result (last captured read data)
//           StallM     freeze F/D/E/M, combinational
//           AdrErrM    misaligned access flag, combinational
//           bus        data-memory bus, master side
// -----------------------------------------------------------------------------
module dmem_stage #(
    parameter int WB_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         MemReadM,
    input  logic         MemWriteM,
    input  logic [31:0]  AluOutM,
    input  logic [31:0]  WriteDataM,
    output logic [31:0]  ReadDataM,
    output logic         StallM,
    output logic         AdrErrM,
    dmem_stage_if.master bus
);

    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] WB_FULL = CW'(WB_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        RD_REQ  = 2'd2,
        RD_DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic [29:0]    ld_addr_q, ld_addr_d;
    logic [31:0]    rdata_q, rdata_d;

    // Buffer storage holds only the word address; the byte offset is always 0.
    logic [29:0]    wb_addr_q [WB_DEPTH];
    logic [31:0]    wb_data_q [WB_DEPTH];

    logic aligned;
    logic wb_full;
    logic wb_busy;
    logic store_ok;
    logic load_ok;
    logic push;
    logic pop;

    assign aligned  = (AluOutM[1:0] == 2'b00);
    assign AdrErrM  = (MemReadM | MemWriteM) & ~aligned;
    assign wb_full  = (count_q == WB_FULL);

    // The buffer owns the bus whenever it holds data, except while the load
    // read is outstanding (which only starts once the buffer is empty).
    assign wb_busy  = (count_q != '0) && (state_q != RD_REQ);
    assign pop      = wb_busy & bus.mem_ack;

    // New M-stage instructions are only looked at in IDLE; in the other
    // states the inputs still show the stalled load itself.
    assign store_ok = (state_q == IDLE) && MemWriteM && aligned;
    assign load_ok  = (state_q == IDLE) && MemReadM && !MemWriteM && aligned;

    // Fullness is judged at cycle start, so a same-cycle pop does not admit
    // the store; it is pushed on the following edge instead.
    assign push     = store_ok && !wb_full;

    assign bus.mem_req   = wb_busy | (state_q == RD_REQ);
    assign bus.mem_we    = (state_q != RD_REQ);
    assign bus.mem_addr  = (state_q == RD_REQ) ? {ld_addr_q, 2'b00}
                                               : {wb_addr_q[head_q], 2'b00};
    assign bus.mem_wdata = wb_data_q[head_q];
    assign ReadDataM     = rdata_q;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        state_d   = state_q;
        ld_addr_d = ld_addr_q;
        rdata_d   = rdata_q;
        StallM    = 1'b0;

        if (push) begin
            tail_d = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (store_ok && wb_full) begin
                    StallM = 1'b1;
                end
                if (load_ok) begin
                    StallM    = 1'b1;
                    ld_addr_d = AluOutM[31:2];
                    // An ack on the last buffered write lets the read start
                    // straight away.
                    state_d   = (count_d == '0) ? RD_REQ : DRAIN;
                end
            end
            DRAIN: begin
                StallM = 1'b1;
                if (count_d == '0) begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                StallM = 1'b1;
                if (bus.mem_ack) begin
                    rdata_d = bus.mem_rdata;
                    state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            ld_addr_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            ld_addr_q <= ld_addr_d;
            rdata_q   <= rdata_d;
        end
    end

    // Entry contents need no reset: an entry is only read while count>0.
    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr_q[tail_q] <= AluOutM[31:2];
            wb_data_q[tail_q] <= WriteDataM;
        end
    end

endmodule

// File: tb/tb_dmem_stage.sv
// -----------------------------------------------------------------------------
// tb_dmem_stage
// Purpose : directed self-checking bench for dmem_stage. Inputs change 1 ns
//           after each rising edge; outputs are compared 1 ns later.
// -----------------------------------------------------------------------------
module tb_dmem_stage;

    logic        clk;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] AluOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        AdrErrM;

    int checks   = 0;
    int failures = 0;

    dmem_stage_if bus ();

    dmem_stage #(.WB_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .AluOutM    (AluOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .AdrErrM    (AdrErrM),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        AluOutM    = 32'h0;
        WriteDataM = 32'h0;
    endtask

    task automatic test_reset;
        idle_inputs();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        reset = 1'b0;
        step();
        step();
        #1;
        checks++; if (ReadDataM !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", ReadDataM); end
        checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", StallM); end
        checks++; if (AdrErrM !== 1'b0) begin failures++; $display("FAIL reset_adrerr got=%b exp=0", AdrErrM); end
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus.mem_req); end
        reset = 1'b1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_store_burst;
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            MemWriteM  = 1'b1;
            AluOutM    = 32'h100 + 4 * i;
            WriteDataM = 32'hA0 + i;
            #1;
            checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL burst_nostall_%0d got=%b exp=0", i, StallM); end
            if (i == 0) begin
                checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL burst_empty_req got=%b exp=0", bus.mem_req); end
            end else begin
                checks++;
                if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_wdata !== 32'hA0) begin
                    failures++;
                    $display("FAIL burst_head_%0d got req=%b we=%b addr=%h data=%h exp req=1 we=1 addr=100 data=a0",
                             i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
                end
            end
            step();
        end
        // Fifth store finds the buffer full.
        AluOutM    = 32'h110;
        WriteDataM = 32'hA4;
        #1;
        checks++; if (StallM !== 1'b1) begin failures++; $display("FAIL burst_full_stall got=%b exp=1", StallM); end
        bus.mem_ack = 1'b1;
        #1;
        checks++; if (StallM !== 1'b1) begin failures++; $display("FAIL burst_full_pop_stall got=%b exp=1", StallM); end
        step();
        bus.mem_ack = 1'b0;
        #1;
        checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL burst_retry_stall got=%b exp=0", StallM); end
        checks++; if (bus.mem_addr !== 32'h104) begin failures++; $display("FAIL burst_newhead got=%h exp=104", bus.mem_addr); end
        step();
        idle_inputs();
        bus.mem_ack = 1'b1;
        for (int i = 1; i < 5; i++) begin
            #1;
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 + 4 * i || bus.mem_wdata !== 32'hA0 + i) begin
                failures++;
                $display("FAIL burst_drain_%0d got req=%b addr=%h data=%h exp req=1 addr=%h data=%h",
                         i, bus.mem_req, bus.mem_addr, bus.mem_wdata, 32'h100 + 4 * i, 32'hA0 + i);
            end
            step();
        end
        bus.mem_ack = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL burst_empty_after got=%b exp=0", bus.mem_req); end
        step();
        $display("test_store_burst done");
    endtask

    task automatic test_load_after_store;
        bus.mem_ack = 1'b0;
        MemWriteM  = 1'b1;
        AluOutM    = 32'h200;
        WriteDataM = 32'hDEADBEEF;
        #1;
        checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL las_store_stall got=%b exp=0", StallM); end
        step();
        // Load presented; one store is buffered.
        MemWriteM = 1'b0;
        MemReadM  = 1'b1;
        #1;
        checks++;
        if (StallM !== 1'b1 || bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h200) begin
            failures++;
            $display("FAIL las_c1 got stall=%b req=%b we=%b addr=%h exp stall=1 req=1 we=1 addr=200",
                     StallM, bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        step();
        #1;
        checks++;
        if (StallM !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL las_drain got stall=%b we=%b data=%h exp stall=1 we=1 data=deadbeef",
                     StallM, bus.mem_we, bus.mem_wdata);
        end
        step();
        bus.mem_ack = 1'b1;
        #1;
        checks++; if (StallM !== 1'b1) begin failures++; $display("FAIL las_drain_ack_stall got=%b exp=1", StallM); end
        step();
        bus.mem_ack = 1'b0;
        #1;
        checks++;
        if (StallM !== 1'b1 || bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h200) begin
            failures++;
            $display("FAIL las_rdreq got stall=%b req=%b we=%b addr=%h exp stall=1 req=1 we=0 addr=200",
                     StallM, bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        step();
        #1;
        checks++; if (StallM !== 1'b1 || bus.mem_we !== 1'b0) begin failures++; $display("FAIL las_rdwait got stall=%b we=%b exp stall=1 we=0", StallM, bus.mem_we); end
        step();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
        #1;
        checks++; if (StallM !== 1'b1) begin failures++; $display("FAIL las_rdack_stall got=%b exp=1", StallM); end
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        #1;
        checks++;
        if (StallM !== 1'b0 || ReadDataM !== 32'hDEADBEEF || bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL las_done got stall=%b data=%h req=%b exp stall=0 data=deadbeef req=0",
                     StallM, ReadDataM, bus.mem_req);
        end
        step();
        idle_inputs();
        #1;
        checks++; if (StallM !== 1'b0 || ReadDataM !== 32'hDEADBEEF) begin failures++; $display("FAIL las_hold got stall=%b data=%h exp stall=0 data=deadbeef", StallM, ReadDataM); end
        step();
        $display("test_load_after_store done");
    endtask

    task automatic test_min_latency;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h12345678;
        MemReadM = 1'b1;
        AluOutM  = 32'h40;
        #1;
        checks++; if (StallM !== 1'b1 || bus.mem_req !== 1'b0) begin failures++; $display("FAIL minlat_c0 got stall=%b req=%b exp stall=1 req=0", StallM, bus.mem_req); end
        step();
        #1;
        checks++;
        if (StallM !== 1'b1 || bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h40) begin
            failures++;
            $display("FAIL minlat_c1 got stall=%b req=%b we=%b addr=%h exp stall=1 req=1 we=0 addr=40",
                     StallM, bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        step();
        #1;
        checks++; if (StallM !== 1'b0 || ReadDataM !== 32'h12345678) begin failures++; $display("FAIL minlat_done got stall=%b data=%h exp stall=0 data=12345678", StallM, ReadDataM); end
        step();
        idle_inputs();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        #1;
        checks++; if (ReadDataM !== 32'h12345678 || StallM !== 1'b0) begin failures++; $display("FAIL minlat_hold got stall=%b data=%h exp stall=0 data=12345678", StallM, ReadDataM); end
        step();
        $display("test_min_latency done");
    endtask

    task automatic test_misaligned;
        bus.mem_ack = 1'b0;
        // One aligned store parked in the buffer to observe the count.
        MemWriteM  = 1'b1;
        AluOutM    = 32'h800;
        WriteDataM = 32'h88;
        #1;
        checks++; if (AdrErrM !== 1'b0) begin failures++; $display("FAIL mis_aligned_flag got=%b exp=0", AdrErrM); end
        step();
        MemWriteM = 1'b0;
        MemReadM  = 1'b1;
        AluOutM   = 32'h41;
        #1;
        checks++; if (AdrErrM !== 1'b1 || StallM !== 1'b0) begin failures++; $display("FAIL mis_lw got adrerr=%b stall=%b exp adrerr=1 stall=0", AdrErrM, StallM); end
        step();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b1;
        AluOutM    = 32'h102;
        WriteDataM = 32'h99;
        #1;
        checks++;
        if (AdrErrM !== 1'b1 || StallM !== 1'b0 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h800) begin
            failures++;
            $display("FAIL mis_sw got adrerr=%b stall=%b we=%b addr=%h exp adrerr=1 stall=0 we=1 addr=800",
                     AdrErrM, StallM, bus.mem_we, bus.mem_addr);
        end
        step();
        idle_inputs();
        bus.mem_ack = 1'b1;
        #1;
        checks++; if (StallM !== 1'b0 || bus.mem_addr !== 32'h800) begin failures++; $display("FAIL mis_after got stall=%b addr=%h exp stall=0 addr=800", StallM, bus.mem_addr); end
        step();
        bus.mem_ack = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL mis_count got req=%b exp=0", bus.mem_req); end
        // Load and store together behave as a store.
        MemReadM   = 1'b1;
        MemWriteM  = 1'b1;
        AluOutM    = 32'h300;
        WriteDataM = 32'h33;
        #1;
        checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL both_stall got=%b exp=0", StallM); end
        step();
        idle_inputs();
        #1;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h300 || bus.mem_wdata !== 32'h33 || StallM !== 1'b0) begin
            failures++;
            $display("FAIL both_write got req=%b we=%b addr=%h data=%h stall=%b exp req=1 we=1 addr=300 data=33 stall=0",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, StallM);
        end
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0 || StallM !== 1'b0) begin failures++; $display("FAIL both_end got req=%b stall=%b exp req=0 stall=0", bus.mem_req, StallM); end
        step();
        $display("test_misaligned done");
    endtask

    task automatic test_wrap;
        int i = 0;
        int j = 0;
        int cyc = 0;
        int stalls = 0;
        while (j < 10 && cyc < 100) begin
            MemWriteM   = (i < 10);
            AluOutM     = 32'h400 + 4 * i;
            WriteDataM  = 32'h5000 + i;
            bus.mem_ack = cyc[0];
            #1;
            if (bus.mem_ack && bus.mem_req) begin
                checks++;
                if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h400 + 4 * j || bus.mem_wdata !== 32'h5000 + j) begin
                    failures++;
                    $display("FAIL wrap_order_%0d got we=%b addr=%h data=%h exp we=1 addr=%h data=%h",
                             j, bus.mem_we, bus.mem_addr, bus.mem_wdata, 32'h400 + 4 * j, 32'h5000 + j);
                end
                j++;
            end
            if (StallM) stalls++;
            if (i < 10 && !StallM) i++;
            step();
            cyc++;
        end
        idle_inputs();
        bus.mem_ack = 1'b0;
        #1;
        checks++; if (j != 10 || i != 10) begin failures++; $display("FAIL wrap_timeout got acks=%0d pushes=%0d exp 10 10", j, i); end
        checks++; if (stalls == 0) begin failures++; $display("FAIL wrap_full got stalls=%0d exp >0", stalls); end
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL wrap_empty got req=%b exp=0", bus.mem_req); end
        step();
        $display("test_wrap done");
    endtask

    task automatic test_reset_mid_read;
        bus.mem_ack = 1'b0;
        MemReadM = 1'b1;
        AluOutM  = 32'h600;
        step();
        #1;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h600) begin failures++; $display("FAIL rst_rdreq got req=%b we=%b addr=%h exp req=1 we=0 addr=600", bus.mem_req, bus.mem_we, bus.mem_addr); end
        reset = 1'b0;
        step();
        reset = 1'b1;
        idle_inputs();
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || StallM !== 1'b0 || ReadDataM !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid got req=%b stall=%b data=%h exp req=0 stall=0 data=0", bus.mem_req, StallM, ReadDataM);
        end
        // Buffered store is discarded by reset.
        MemWriteM  = 1'b1;
        AluOutM    = 32'h700;
        WriteDataM = 32'h77;
        step();
        idle_inputs();
        #1;
        checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL rst_prestore got req=%b exp=1", bus.mem_req); end
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rst_discard got req=%b exp=0", bus.mem_req); end
        step();
        #1;
        checks++; if (bus.mem_req !== 1'b0 || StallM !== 1'b0) begin failures++; $display("FAIL rst_after got req=%b stall=%b exp 0 0", bus.mem_req, StallM); end
        $display("test_reset_mid_read done");
    endtask

    initial begin
        test_reset();
        test_store_burst();
        test_load_after_store();
        test_min_latency();
        test_misaligned();
        test_wrap();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/dmem_stage.md
Name: dmem_stage

Overview:
- Memory-stage data-access unit. It sits between the pipelined MIPS core's M-stage outputs (MemWriteM, AluOutM, WriteDataM) and a variable-latency data-memory bus, and returns ReadDataM.
- Stores are posted into a write buffer so they retire without stalling.
- Loads drain the write buffer, then perform a handshaked bus read. StallM is raised to the hazard unit until the load data is ready.

Parameters:
- WB_DEPTH, 4, write-buffer entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets the block).
- MemReadM  in  1  M-stage instruction is a load (lw).
- MemWriteM  in  1  M-stage instruction is a store (sw).
- AluOutM  in  32  byte address of the access.
- WriteDataM  in  32  store data.
- ReadDataM  out  32  load result; valid when the load completes.
- StallM  out  1  freeze F/D/E/M; combinational from state and inputs.
- AdrErrM  out  1  misaligned access flag; combinational.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  word-aligned bus address.
- mem_wdata  out  32  bus write data.
- mem_rdata  in  32  read data; valid when mem_ack=1 on a read.
- mem_ack  in  1  transfer completes in this cycle.

Behaviour:
- Reset (reset==0 at edge):
  - state=IDLE; FIFO pointers and count = 0; read-data register = 0.
  - ReadDataM=0, StallM=0, AdrErrM=0, mem_req=0.
  - Applies mid-transfer: mem_req drops the next cycle; buffered stores are discarded.
- Bus handshake:
  - While mem_req=1, mem_we/mem_addr/mem_wdata are held stable until the cycle with mem_ack=1.
  - mem_ack is ignored when mem_req=0.
  - A new request may assert in the cycle after an ack.
- Write buffer:
  - Circular FIFO of {addr, data}, WB_DEPTH entries; wrap-around by pointer modulo.
  - Push: MemWriteM=1, aligned, count<WB_DEPTH.
  - Pop: head write acked.
  - Simultaneous push and pop leaves count unchanged.
- Store:
  - If count==WB_DEPTH at cycle start: StallM=1, no push. A pop in the same cycle does not clear the stall; the push occurs next cycle.
  - Otherwise StallM=0 and the store is pushed this edge.
- Misalignment: AluOutM[1:0]≠0 with MemReadM or MemWriteM gives AdrErrM=1, no push, no read, StallM=0.
- Illegal combination: MemReadM=MemWriteM=1 is treated as a store only.
- Write drain: whenever count>0 and state is not RD_REQ, drive mem_req=1, mem_we=1 from the FIFO head.
- FSM states: IDLE, DRAIN, RD_REQ, RD_DONE.
  - IDLE, aligned load: StallM=1. If count==0 (including pop this cycle leaving 0), go to RD_REQ; otherwise go to DRAIN. Latch the address.
  - DRAIN: StallM=1; go to RD_REQ on the edge where count becomes 0.
  - RD_REQ: mem_req=1, mem_we=0, mem_addr=latched address, StallM=1. On mem_ack, capture mem_rdata and go to RD_DONE.
  - RD_DONE: StallM=0; ReadDataM=captured data; return to IDLE next edge.
- Load timing: minimum latency is 2 stall cycles (load seen at t, req at t+1 acked at t+1, result at t+2).
- Load data ordering: loads never bypass buffered stores. Because the buffer drains first, the load returns the value written by a preceding store to the same word.
- ReadDataM holds its last captured value outside RD_DONE.
- Widths: mem_addr = {AluOutM[31:2],2'b00}; no sub-word accesses.

Test Plan:
- Store burst: 4 sw to 0x100..0x10C, mem_ack tied 0 → no stall on the first 4; a 5th sw gives StallM=1. Ack one → 5th pushed next cycle, StallM=0.
- Load after store: sw 0xDEADBEEF→0x200, then lw 0x200, ack latency 3 → state passes DRAIN→RD_REQ, ReadDataM=0xDEADBEEF in RD_DONE, StallM low exactly that cycle.
- Minimum-latency load: empty buffer, mem_ack=1 always, lw 0x40 (mem_rdata=0x12345678) → StallM=1 for 2 cycles, then ReadDataM=0x12345678, StallM=0.
- Misaligned: lw 0x41 and sw 0x102 → AdrErrM=1, no mem_req, StallM=0, FIFO count unchanged.
- Wrap-around: 10 stores with ack every 2nd cycle → bus sees addresses in program order, pointers wrap past WB_DEPTH, final count=0.
- Reset mid-read: assert reset=0 while in RD_REQ → next cycle mem_req=0, state IDLE, StallM=0, ReadDataM=0, count=0.
